bounce_gen: RTL and testbench

Switch-bounce emulator: drives a contact-bounce waveform on a button-level output whenever the requested clean level changes, then settles to that level. It is the transmitter-side counterpart of the team's button debouncer. It sits in the test/demo fabric and feeds the debouncer's `btn` input, so thresholds can be exercised on-board and in simulation without a physical pushbutton. A 16-bit LFSR provides pseudo-random bounce gaps.

---
 rtl/bounce_gen.sv | 145 ++++++++++++++
 tb/tb_bounce_gen.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bounce_gen.sv
// bounce_gen -- switch-bounce emulator.
//
// Whenever the requested clean level changes, this block drives a contact-bounce
// waveform on btn_out for a fixed window and then settles to the requested level.
// It feeds the button debouncer's btn input, so thresholds can be exercised
// without a physical pushbutton.
//
// Parameters:
//   BOUNCE_CYCLES  length of the bounce window in clk cycles (>= 2)
//   MIN_GAP        minimum cycles between bounce toggles (>= 1)
//   GAP_BITS       LFSR bits added to MIN_GAP for the random part of a gap (1..16)
//   SEED           LFSR reset value; 0 is replaced by 16'h0001
//
// Ports:
//   clk           system clock
//   reset         asynchronous, active-high reset
//   level_in      requested clean button level, synchronous to clk
//   btn_out       emulated bouncy button signal (registered)
//   busy          high while a bounce window is in progress (registered)
//   toggle_count  bounce toggles in the current/last window, saturates at 255
//
// Build option:
//   BOUNCE_GEN_FIXED_GAP_EN  when defined, the LFSR is removed and every gap is
//                            exactly MIN_GAP (deterministic periodic bounce).
//                            SEED is only used when this macro is undefined.

module bounce_gen #(
  parameter int          BOUNCE_CYCLES = 20000,
  parameter int          MIN_GAP       = 50,
  parameter int          GAP_BITS      = 8,
  parameter logic [15:0] SEED          = 16'hACE1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       level_in,
  output logic       btn_out,
  output logic       busy,
  output logic [7:0] toggle_count
);

  // The gap counter must hold the largest possible gap, MIN_GAP + 2^GAP_BITS - 1.
  localparam int GAP_MAX = MIN_GAP + (1 << GAP_BITS) - 1;
  localparam int GAP_W   = $clog2(GAP_MAX + 1);
  localparam int WIN_W   = $clog2(BOUNCE_CYCLES + 1);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_BOUNCE = 1'b1;

  logic [0:0]       state;
  logic             stable;
  logic             target;
  logic [WIN_W-1:0] win_cnt;
  logic [GAP_W-1:0] gap_cnt;
  logic [GAP_W-1:0] gap_next;
  logic             request;
  logic             win_last;
  logic             gap_expire;
  logic             gap_load;

  assign request  = (state == ST_IDLE) && (level_in != stable);
  // win_cnt is cleared on the request edge, so it reads k-1 at the k-th edge
  // of the window; the window closes on edge N + BOUNCE_CYCLES.
  assign win_last   = (state == ST_BOUNCE) && (win_cnt == WIN_W'(BOUNCE_CYCLES - 1));
  // A gap of g loaded at edge M expires (toggles) at edge M + g.
  assign gap_expire = (state == ST_BOUNCE) && (gap_cnt == GAP_W'(1));
  // Window end wins over a coincident expiry, and that expiry loads no new gap.
  assign gap_load   = request || (gap_expire && !win_last);

`ifdef BOUNCE_GEN_FIXED_GAP_EN
  assign gap_next = GAP_W'(MIN_GAP);
`else
  localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;

  logic [15:0]         lfsr;
  logic                lfsr_fb;
  logic [GAP_BITS-1:0] lfsr_low;

  assign lfsr_fb  = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
  assign lfsr_low = lfsr[GAP_BITS-1:0];
  // The gap uses the LFSR value present at the load; the LFSR then steps.
  assign gap_next = GAP_W'(MIN_GAP) + GAP_W'(lfsr_low);

  // Fibonacci LFSR, stepped once per gap load so the gap sequence does not
  // depend on how long the block sits idle between windows.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr <= SEED_EFF;
    end else if (gap_load) begin
      lfsr <= {lfsr[14:0], lfsr_fb};
    end
  end
`endif

  // Main controller: IDLE mirrors the stable level and waits for a request;
  // BOUNCE counts the window, toggles btn_out on each gap expiry and finally
  // forces btn_out and the stable level to the captured target.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      stable       <= 1'b0;
      target       <= 1'b0;
      btn_out      <= 1'b0;
      busy         <= 1'b0;
      toggle_count <= 8'd0;
      win_cnt      <= '0;
      gap_cnt      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          btn_out <= stable;
          if (request) begin
            target       <= level_in;
            btn_out      <= level_in;
            busy         <= 1'b1;
            win_cnt      <= '0;
            toggle_count <= 8'd0;
            gap_cnt      <= gap_next;
            state        <= ST_BOUNCE;
          end
        end
        ST_BOUNCE: begin
          win_cnt <= win_cnt + WIN_W'(1);
          if (win_last) begin
            btn_out <= target;
            stable  <= target;
            busy    <= 1'b0;
            state   <= ST_IDLE;
          end else if (gap_expire) begin
            btn_out <= ~btn_out;
            if (toggle_count != 8'hFF) begin
              toggle_count <= toggle_count + 8'd1;
            end
            gap_cnt <= gap_next;
          end else begin
            gap_cnt <= gap_cnt - GAP_W'(1);
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bounce_gen.sv
// tb_bounce_gen -- scoreboard bench for bounce_gen.
//
// Two instances share level_in and reset: dut (SEED = 16'hACE1) and dut0
// (SEED = 0, which must behave as seed 16'h0001). Each request pushes the
// expected btn_out/busy/toggle_count events of the window into a queue; a
// monitor pops one entry on every change of btn_out or busy of dut.
// Works with and without BOUNCE_GEN_FIXED_GAP_EN.

module tb_bounce_gen;

  localparam int BC = 100;
  localparam int MG = 10;
  localparam int GB = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       level_in;
  logic       btn_out;
  logic       busy;
  logic [7:0] toggle_count;
  logic       btn_out0;
  logic       busy0;
  logic [7:0] toggle_count0;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;

  typedef struct {
    int   cyc;
    logic btn;
    logic busy;
    int   cnt;
  } ev_t;

  ev_t         exp_q[$];
  ev_t         mon_e;
  logic [15:0] model_lf;
  logic [15:0] model_lf0;
  int          model_cnt;
  int          model_cnt0;
  logic        model_stable;
  logic        prev_btn  = 1'b0;
  logic        prev_busy = 1'b0;

  bounce_gen #(.BOUNCE_CYCLES(BC), .MIN_GAP(MG), .GAP_BITS(GB), .SEED(16'hACE1)) dut (
    .clk(clk), .reset(reset), .level_in(level_in),
    .btn_out(btn_out), .busy(busy), .toggle_count(toggle_count)
  );

  bounce_gen #(.BOUNCE_CYCLES(BC), .MIN_GAP(MG), .GAP_BITS(GB), .SEED(16'h0000)) dut0 (
    .clk(clk), .reset(reset), .level_in(level_in),
    .btn_out(btn_out0), .busy(busy0), .toggle_count(toggle_count0)
  );

  // Clock and edge counter: after posedge k, cyc reads k.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference gap: MIN_GAP plus the low LFSR bits, then one Fibonacci step.
  function automatic int next_gap(inout logic [15:0] lf);
    int g;
`ifdef BOUNCE_GEN_FIXED_GAP_EN
    g = MG;
`else
    g  = MG + int'(lf & 16'((1 << GB) - 1));
    lf = {lf[14:0], lf[15] ^ lf[13] ^ lf[12] ^ lf[10]};
`endif
    return g;
  endfunction

  // Reference window starting on edge n; optionally queues its events.
  function automatic int model_window(input int n, input logic tgt,
                                      inout logic [15:0] lf, input bit push);
    int   t;
    int   cnt;
    logic b;
    b   = tgt;
    cnt = 0;
    if (push) exp_q.push_back('{n, tgt, 1'b1, 0});
    t = n + next_gap(lf);
    while (t < n + BC) begin
      b = ~b;
      if (cnt < 255) cnt++;
      if (push) exp_q.push_back('{t, b, 1'b1, cnt});
      t = t + next_gap(lf);
    end
    if (push) exp_q.push_back('{n + BC, tgt, 1'b0, cnt});
    return cnt;
  endfunction

  // Monitor: every change of btn_out/busy must match the head of the queue;
  // a head whose edge has passed without a change is a missed event.
  always @(negedge clk) begin
    if (reset) begin
      prev_btn  = btn_out;
      prev_busy = busy;
    end else begin
      if (btn_out !== prev_btn || busy !== prev_busy) begin
        tests_run++;
        if (exp_q.size() == 0) begin
          tests_failed++;
          $display("[TB] FAIL unexpected_event: cyc=%0d btn=%b busy=%b cnt=%0d, required no change",
                   cyc, btn_out, busy, toggle_count);
        end else begin
          mon_e = exp_q.pop_front();
          if (mon_e.cyc != cyc || mon_e.btn !== btn_out || mon_e.busy !== busy ||
              int'(toggle_count) != mon_e.cnt) begin
            tests_failed++;
            $display("[TB] FAIL event: got cyc=%0d btn=%b busy=%b cnt=%0d, required cyc=%0d btn=%b busy=%b cnt=%0d",
                     cyc, btn_out, busy, toggle_count, mon_e.cyc, mon_e.btn, mon_e.busy, mon_e.cnt);
          end
        end
      end else if (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
        tests_run++;
        tests_failed++;
        mon_e = exp_q.pop_front();
        $display("[TB] FAIL missed_event: got no change by cyc=%0d, required cyc=%0d btn=%b busy=%b cnt=%0d",
                 cyc, mon_e.cyc, mon_e.btn, mon_e.busy, mon_e.cnt);
      end
      prev_btn  = btn_out;
      prev_busy = busy;
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    tests_run++;
    if (actual != expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, required %0d", name, actual, expected);
    end
  endtask

  // Drive level_in 2 time units after a posedge; it is sampled on the next edge.
  task automatic applyStimulus(input logic lvl, output int n);
    @(posedge clk);
    #2;
    level_in = lvl;
    n = cyc + 1;
  endtask

  task automatic at_cycle(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic model_start(input int n, input logic lvl);
    model_cnt    = model_window(n, lvl, model_lf, 1'b1);
    model_cnt0   = model_window(n, lvl, model_lf0, 1'b0);
    model_stable = lvl;
  endtask

  task automatic start_window(input logic lvl, output int n);
    applyStimulus(lvl, n);
    model_start(n, lvl);
  endtask

  // Wait (bounded) until the monitor has consumed every queued event.
  task automatic wait_drain(input string name, input int limit);
    for (int i = 0; i < limit && exp_q.size() != 0; i++) @(posedge clk);
    if (exp_q.size() != 0) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL %s_timeout: got %0d events pending, required 0", name, exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic check_settled(input string name);
    checkOutput({name, "_btn"}, int'(btn_out), int'(model_stable));
    checkOutput({name, "_busy"}, int'(busy), 0);
    checkOutput({name, "_count"}, int'(toggle_count), model_cnt);
    checkOutput({name, "_btn0"}, int'(btn_out0), int'(model_stable));
    checkOutput({name, "_count0"}, int'(toggle_count0), model_cnt0);
  endtask

  initial begin
    int n;
    int n2;
    reset        = 1'b1;
    level_in     = 1'b0;
    model_lf     = 16'hACE1;
    model_lf0    = 16'h0001;
    model_stable = 1'b0;
    model_cnt    = 0;
    model_cnt0   = 0;

    // Reset values.
    repeat (2) @(posedge clk);
    #2;
    checkOutput("reset_btn", int'(btn_out), 0);
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_count", int'(toggle_count), 0);
    reset = 1'b0;

    // 0 -> 1 window.
    start_window(1'b1, n);
    wait_drain("rise", 3 * BC);
    check_settled("rise");
`ifdef BOUNCE_GEN_FIXED_GAP_EN
    checkOutput("rise_fixed_count", int'(toggle_count), 9);
`endif

    // 1 -> 0 mirror window.
    start_window(1'b0, n);
    wait_drain("fall", 3 * BC);
    check_settled("fall");

    // level_in 1 -> 0 -> 1 during the window: no second window.
    start_window(1'b1, n);
    at_cycle(n + 20);
    level_in = 1'b0;
    at_cycle(n + 30);
    level_in = 1'b1;
    wait_drain("ignore", 3 * BC);
    repeat (10) @(posedge clk);
    check_settled("ignore");

    // Single 1 -> 0 -> 1 where the final request arrives mid-window:
    // a second window starts on edge N + BC + 1.
    start_window(1'b0, n);
    at_cycle(n + 50);
    level_in = 1'b1;
    model_start(n + BC + 1, 1'b1);
    wait_drain("pending", 6 * BC);
    check_settled("pending");

    // Reset mid-window, then an immediate new window after release.
    start_window(1'b0, n);
    at_cycle(n + 45);
    reset = 1'b1;
    #1;
    checkOutput("midreset_btn", int'(btn_out), 0);
    checkOutput("midreset_busy", int'(busy), 0);
    checkOutput("midreset_count", int'(toggle_count), 0);
    checkOutput("midreset_busy0", int'(busy0), 0);
    exp_q.delete();
    model_lf     = 16'hACE1;
    model_lf0    = 16'h0001;
    model_stable = 1'b0;
    level_in     = 1'b1;
    @(posedge clk);
    #2;
    reset = 1'b0;
    n2 = cyc + 1;
    model_start(n2, 1'b1);
    wait_drain("postreset", 3 * BC);
    check_settled("postreset");

    // A glitch back to the stable level between edges produces no window.
    @(posedge clk);
    #2;
    level_in = 1'b0;
    #1;
    level_in = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk);
    check_settled("glitch");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
